binary_search: RTL and testbench
================================

BINARY_SEARCH -- requirements
Module: binary_search

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port enable, input, 1, clock enable; when low, all state is frozen, including the edge detectors.
REQ-004 SHALL have ports clear, push and search, input, 1 each, level command inputs acted on at their rising edge.
REQ-005 SHALL have port din, input, 16, value to append to the table, sourced from the upstream sorter's dout.
REQ-006 SHALL have port key, input, 16, search key, latched when a search starts.
REQ-007 SHALL have ports full, empty and idle, output, 1 each: count==255, count==0, and FSM in IDLE.
REQ-008 SHALL have port count, output, 8, number of stored entries.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when a search completes.
REQ-010 SHALL have port found, output, 1, result of the last completed search.
REQ-011 SHALL have port index, output, 8, match position, or the insertion point on a miss.
REQ-012 SHALL have port order_err, output, 1, sticky flag set by a non-ascending push (see Configuration).

Function
REQ-013 SHALL hold a 256x16 table A; count is 8-bit and capacity is 255 entries.
REQ-014 SHALL detect rising edges with a 2-bit shift register per command; a command is valid when its register equals 01.
REQ-015 In IDLE, SHALL apply priority clear > push > search; edges arriving outside IDLE are discarded.
REQ-016 SHALL use FSM states IDLE, CLEAR, PUSH, S_INIT, S_PROBE, S_CMP, S_DONE, each advancing one state per enabled cycle.
REQ-017 CLEAR SHALL set count=0, then return to IDLE; table contents are don't-care.
REQ-018 PUSH SHALL write A[count]=din and increment count, then return to IDLE.
REQ-019 PUSH when full SHALL perform no write and leave count at 255.
REQ-020 S_INIT SHALL latch key, set lo=0 and hi=count (9-bit), then go to S_PROBE.
REQ-021 S_PROBE with lo>=hi SHALL set found=0 and index=lo[7:0], then go to S_DONE.
REQ-022 S_PROBE with lo<hi SHALL set mid=(lo+hi)>>1, then go to S_CMP.
REQ-023 S_CMP SHALL compare A[mid] against key, unsigned:
  - equal: found=1, index=mid, go to S_DONE;
  - A[mid]<key: lo=mid+1, go to S_PROBE;
  - A[mid]>key: hi=mid, go to S_PROBE.
REQ-024 S_DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-025 found and index SHALL hold their values until the next search completes or reset.
REQ-026 Worst-case search latency SHALL be 2+2*8+1 cycles from the S_INIT entry, with at most 8 compares.
REQ-027 With duplicate keys, SHALL return whichever matching index the algorithm above reaches first (deterministic).
REQ-028 A search on an empty table SHALL complete via S_INIT, S_PROBE, S_DONE with found=0 and index=0.

Reset
REQ-029 rstn low SHALL asynchronously set state=IDLE and count=0.
REQ-030 rstn low SHALL asynchronously clear the edge registers, lo, hi, mid, the latched key, done, found, index and order_err.
REQ-031 Reset mid-search SHALL abort the search with no done pulse; table contents are not reset.

Configuration
REQ-032 Macro BINARY_SEARCH_ORDER_CHECK_EN defined: PUSH with count>0 and din<A[count-1] SHALL set order_err=1; the value is still written; order_err is cleared only by CLEAR or reset.
REQ-033 Macro BINARY_SEARCH_ORDER_CHECK_EN undefined: order_err SHALL be tied to 0 and no comparison logic SHALL be present.

Verification
REQ-034 Push 10,20,30,40,50, then search key 30 -> done with found=1, index=2, 1 compare.
REQ-035 Same table, search key 35 -> found=0, index=3; search key 5 -> found=0, index=0; search key 60 -> found=0, index=5.
REQ-036 After clear, search key 7 -> done 3 cycles after S_INIT entry, found=0, index=0, empty=1.
REQ-037 256 pushes of ascending values -> count=255, full=1, A[254] equals the 255th value, 256th push ignored.
REQ-038 With the macro defined, push 10 then 5 -> order_err=1, remaining 1 after further pushes, 0 after clear.
REQ-039 Drop rstn during S_CMP, then release -> idle=1, count=0, no done pulse; search asserted during an active search is ignored.

Source files
------------

// File: rtl/binary_search.sv
// Sorted 255-entry table with push/clear and a binary-search lookup; commands are edge-detected levels.
// Optional build macro BINARY_SEARCH_ORDER_CHECK_EN adds a sticky non-ascending-push flag.
module binary_search (
   input  logic        clk,
   input  logic        rstn,
   input  logic        enable,
   input  logic        clear,
   input  logic        push,
   input  logic        search,
   input  logic [15:0] din,
   input  logic [15:0] key,
   output logic        full,
   output logic        empty,
   output logic        idle,
   output logic [7:0]  count,
   output logic        done,
   output logic        found,
   output logic [7:0]  index,
   output logic        order_err
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] CLEAR   = 3'd1;
   localparam logic [2:0] PUSH    = 3'd2;
   localparam logic [2:0] S_INIT  = 3'd3;
   localparam logic [2:0] S_PROBE = 3'd4;
   localparam logic [2:0] S_CMP   = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   logic [15:0] tbl [0:255];
   logic [2:0]  state;
   logic [1:0]  clr_sr, push_sr, srch_sr;
   logic [8:0]  lo, hi;
   logic [7:0]  mid;
   logic [15:0] key_q;
   logic        res_found;
   logic [7:0]  res_index;

   assign full  = (count == 8'd255);
   assign empty = (count == 8'd0);
   assign idle  = (state == IDLE);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         count     <= 8'd0;
         clr_sr    <= 2'b00;
         push_sr   <= 2'b00;
         srch_sr   <= 2'b00;
         lo        <= 9'd0;
         hi        <= 9'd0;
         mid       <= 8'd0;
         key_q     <= 16'd0;
         res_found <= 1'b0;
         res_index <= 8'd0;
         done      <= 1'b0;
         found     <= 1'b0;
         index     <= 8'd0;
      end else if (enable) begin
         clr_sr  <= {clr_sr[0], clear};
         push_sr <= {push_sr[0], push};
         srch_sr <= {srch_sr[0], search};
         done    <= 1'b0;
         case (state)
            IDLE: begin
               // edges seen while busy simply shift out and are lost
               if (clr_sr == 2'b01)       state <= CLEAR;
               else if (push_sr == 2'b01) state <= PUSH;
               else if (srch_sr == 2'b01) state <= S_INIT;
            end
            CLEAR: begin
               count <= 8'd0;
               state <= IDLE;
            end
            PUSH: begin
               if (!full) count <= count + 8'd1;
               state <= IDLE;
            end
            S_INIT: begin
               key_q <= key;
               lo    <= 9'd0;
               hi    <= {1'b0, count};
               state <= S_PROBE;
            end
            S_PROBE: begin
               if (lo >= hi) begin
                  res_found <= 1'b0;
                  res_index <= lo[7:0];
                  state     <= S_DONE;
               end else begin
                  mid   <= 8'((lo + hi) >> 1);
                  state <= S_CMP;
               end
            end
            S_CMP: begin
               if (tbl[mid] == key_q) begin
                  res_found <= 1'b1;
                  res_index <= mid;
                  state     <= S_DONE;
               end else begin
                  if (tbl[mid] < key_q) lo <= {1'b0, mid} + 9'd1;
                  else                  hi <= {1'b0, mid};
                  state <= S_PROBE;
               end
            end
            S_DONE: begin
               // results publish together with done so they hold between searches
               done  <= 1'b1;
               found <= res_found;
               index <= res_index;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enable && state == PUSH && !full) tbl[count] <= din;
   end

`ifdef BINARY_SEARCH_ORDER_CHECK_EN
   logic [7:0] prev_idx;
   logic       order_viol;
   assign prev_idx   = count - 8'd1;
   assign order_viol = (state == PUSH) && (count != 8'd0) && (din < tbl[prev_idx]);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                order_err <= 1'b0;
      else if (enable) begin
         if (state == CLEAR)    order_err <= 1'b0;
         else if (order_viol)   order_err <= 1'b1;
      end
   end
`else
   assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_binary_search.sv
// Directed bench for binary_search: push/search/clear, full table, mid-search reset, order flag.
module tb_binary_search;
   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        enable = 1'b1;
   logic        clear = 1'b0, push = 1'b0, search = 1'b0;
   logic [15:0] din = 16'd0, key = 16'd0;
   logic        full, empty, idle, done, found, order_err;
   logic [7:0]  count, index;

   int checks = 0;
   int errors = 0;

   binary_search dut (
      .clk(clk), .rstn(rstn), .enable(enable), .clear(clear), .push(push), .search(search),
      .din(din), .key(key), .full(full), .empty(empty), .idle(idle), .count(count),
      .done(done), .found(found), .index(index), .order_err(order_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_push(input logic [15:0] v);
      din  = v;
      push = 1'b1;
      tick();
      push = 1'b0;
      repeat (4) tick();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (4) tick();
   endtask

   // n = cycles from S_INIT entry until done is seen high
   task automatic do_search(input logic [15:0] k, output int n);
      key    = k;
      search = 1'b1;
      tick();
      search = 1'b0;
      tick();
      n = 0;
      while (done !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      chk("search_done_seen", {15'd0, done}, 16'd1);
   endtask

   int n;
   int extra_done;

   initial begin
      #12;
      chk("rst_idle", {15'd0, idle}, 16'd1);
      chk("rst_empty", {15'd0, empty}, 16'd1);
      chk("rst_full", {15'd0, full}, 16'd0);
      chk("rst_count", {8'd0, count}, 16'd0);
      chk("rst_done", {15'd0, done}, 16'd0);
      chk("rst_found", {15'd0, found}, 16'd0);
      chk("rst_index", {8'd0, index}, 16'd0);
      chk("rst_order_err", {15'd0, order_err}, 16'd0);
      rstn = 1'b1;
      tick();

      do_push(16'd10); do_push(16'd20); do_push(16'd30); do_push(16'd40); do_push(16'd50);
      chk("count5", {8'd0, count}, 16'd5);

      do_search(16'd30, n);
      chk("k30_found", {15'd0, found}, 16'd1);
      chk("k30_index", {8'd0, index}, 16'd2);
      chk("k30_latency", 16'(n), 16'd4);
      tick();
      chk("k30_done_pulse", {15'd0, done}, 16'd0);

      do_search(16'd35, n);
      chk("k35_found", {15'd0, found}, 16'd0);
      chk("k35_index", {8'd0, index}, 16'd3);
      chk("k35_latency", 16'(n), 16'd9);
      tick();
      chk("k35_hold_index", {8'd0, index}, 16'd3);

      do_search(16'd5, n);
      chk("k5_found", {15'd0, found}, 16'd0);
      chk("k5_index", {8'd0, index}, 16'd0);
      chk("k5_latency", 16'(n), 16'd9);

      // second search edge while busy must be discarded
      key    = 16'd60;
      search = 1'b1;
      tick();
      search = 1'b0;
      tick();
      tick();
      search = 1'b1;
      tick();
      search = 1'b0;
      n = 2;
      while (done !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      chk("k60_latency", 16'(n), 16'd7);
      chk("k60_found", {15'd0, found}, 16'd0);
      chk("k60_index", {8'd0, index}, 16'd5);
      extra_done = 0;
      repeat (30) begin
         tick();
         if (done === 1'b1) extra_done++;
      end
      chk("busy_search_ignored", 16'(extra_done), 16'd0);

      do_clear();
      chk("clr_empty", {15'd0, empty}, 16'd1);
      do_search(16'd7, n);
      chk("empty_latency", 16'(n), 16'd3);
      chk("empty_found", {15'd0, found}, 16'd0);
      chk("empty_index", {8'd0, index}, 16'd0);

      // enable low freezes edge detection, so this push is never seen
      enable = 1'b0;
      din    = 16'd99;
      push   = 1'b1;
      repeat (3) tick();
      push   = 1'b0;
      repeat (3) tick();
      enable = 1'b1;
      repeat (4) tick();
      chk("enable_frozen_count", {8'd0, count}, 16'd0);

      for (int i = 0; i < 256; i++) do_push(16'(i * 3));
      chk("full_count", {8'd0, count}, 16'd255);
      chk("full_flag", {15'd0, full}, 16'd1);
      do_search(16'd762, n);
      chk("a254_found", {15'd0, found}, 16'd1);
      chk("a254_index", {8'd0, index}, 16'd254);
      do_search(16'd765, n);
      chk("push256_ignored_found", {15'd0, found}, 16'd0);
      chk("push256_ignored_index", {8'd0, index}, 16'd255);

      // reset while the FSM sits in S_CMP
      key    = 16'd762;
      search = 1'b1;
      tick();
      search = 1'b0;
      repeat (3) tick();
      chk("midsearch_busy", {15'd0, idle}, 16'd0);
      rstn = 1'b0;
      #2;
      chk("arst_idle", {15'd0, idle}, 16'd1);
      chk("arst_count", {8'd0, count}, 16'd0);
      chk("arst_found", {15'd0, found}, 16'd0);
      tick();
      rstn = 1'b1;
      extra_done = 0;
      repeat (30) begin
         tick();
         if (done === 1'b1) extra_done++;
      end
      chk("arst_no_done", 16'(extra_done), 16'd0);
      chk("arst_idle_after", {15'd0, idle}, 16'd1);

      do_push(16'd10);
      do_push(16'd5);
`ifdef BINARY_SEARCH_ORDER_CHECK_EN
      chk("order_err_set", {15'd0, order_err}, 16'd1);
      do_push(16'd20);
      chk("order_err_sticky", {15'd0, order_err}, 16'd1);
      do_clear();
      chk("order_err_cleared", {15'd0, order_err}, 16'd0);
`else
      chk("order_err_tied", {15'd0, order_err}, 16'd0);
      chk("order_push_count", {8'd0, count}, 16'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
